vscale_md_ctrl: RTL and testbench
=================================

Name: vscale_md_ctrl

Overview:
- Sequencer directly upstream of vscale_mul_div.
- Accepts one decoded RV32M instruction from the pipeline (funct3, rd, operands) and maps it onto the mul/div request signals.
- Issues the request, waits for the single-cycle response pulse, then holds the result in a writeback register with a valid/ready handshake.
- Handles pipeline kill of an in-flight op and runs a watchdog on the response.

Parameters:
- TIMEOUT_CYCLES, 63: WAIT cycles without md_resp_valid before err is raised (1..255).
- TAG_W, 5: width of the destination-register tag.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  pipeline presents an M-op
- in_ready  out  1  controller accepts the op
- in_funct3  in  3  RV32M funct3
- in_rd  in  TAG_W  destination tag
- in_rs1  in  32  operand 1
- in_rs2  in  32  operand 2
- kill  in  1  flush the current op
- wb_valid  out  1  result available
- wb_ready  in  1  writeback consumes the result
- wb_rd  out  TAG_W  tag of the result
- wb_data  out  32  result
- busy  out  1  state != IDLE
- err  out  1  sticky watchdog error
- md_req_valid  out  1  to vscale_mul_div req_valid
- md_req_ready  in  1  from req_ready
- md_req_op  out  1  MD_OP_MUL / MD_OP_DIV
- md_req_out_sel  out  1  MD_OUT_LO / MD_OUT_HI
- md_req_in_1_signed  out  1  operand 1 signedness
- md_req_in_2_signed  out  1  operand 2 signedness
- md_req_in_1  out  32  operand 1
- md_req_in_2  out  32  operand 2
- md_resp_valid  in  1  one-cycle response pulse
- md_resp_result  in  32  response data

Behaviour:
- Reset (async, active-high), all outputs 0:
  - state=IDLE; in_ready, wb_valid, busy, err, md_req_valid all 0; wb_data/wb_rd 0; killed flag 0; counter 0.
- Decode (funct3 -> op, out_sel, s1, s2):
  - 000 MUL: MUL, LO, 0, 0
  - 001 MULH: MUL, HI, 1, 1
  - 010 MULHSU: MUL, HI, 1, 0
  - 011 MULHU: MUL, HI, 0, 0
  - 100 DIV: DIV, LO, 1, 1
  - 101 DIVU: DIV, LO, 0, 0
  - 110 REM: DIV, HI, 1, 1
  - 111 REMU: DIV, HI, 0, 0
- Timing:
  - All md_req_* outputs come from registers; there is no combinational path from in_* to md_*.
  - md_req_in_* stay stable while md_req_valid=1.
- FSM:
  - IDLE: in_ready = ~kill. On in_valid&in_ready, latch decoded fields, operands and rd → ISSUE.
  - ISSUE: md_req_valid=1.
    - kill → IDLE with no request issued (kill has priority).
    - else md_req_ready → WAIT, counter cleared.
  - WAIT: counter increments each cycle.
    - md_resp_valid with killed=1 → IDLE, response discarded.
    - md_resp_valid with killed=0 → wb_data=md_resp_result → DONE.
    - Counter reaches TIMEOUT_CYCLES before md_resp_valid → err=1 (sticky until reset), killed cleared → IDLE.
    - kill in WAIT sets killed; the state stays WAIT because the mul/div unit cannot abort.
    - kill in the same cycle as md_resp_valid counts as killed.
  - DONE: wb_valid=1; wb_data/wb_rd held stable.
    - wb_ready → IDLE.
    - kill → IDLE with wb_valid dropped; kill wins over wb_ready.
- Latency:
  - Accept at cycle T, md_req_valid at T+1.
  - wb_valid on the cycle after md_resp_valid.
  - New accept no earlier than the cycle after the wb handshake.
- Response pulses:
  - A stray md_resp_valid in IDLE, ISSUE or DONE is ignored.
- Reset mid-op:
  - Returns to IDLE immediately; busy=0.

Optional Feature:
- Macro VSCALE_MD_REUSE_EN.
- Defined:
  - Keep a last-result cache holding funct3, rs1, rs2, result and a valid bit.
  - It is written on every non-killed completion and invalidated on reset and on timeout.
  - On accept with funct3/rs1/rs2 all equal to the cache and cache valid: go IDLE → DONE directly with the cached result and the new rd; no md request is issued.
  - The cache is updated only by real responses.
- Undefined: every accepted op issues to vscale_mul_div.

Decomposition:
- Shared package vscale_md_ctrl_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - funct3 constants MD_F3_MUL … MD_F3_REMU.
- MD_OP_* and MD_OUT_* are reused from vscale_md_constants.vh.
- Sub-module vscale_md_decode: combinational funct3 → {op, out_sel, s1, s2}.

Test Plan:
- MULH, rs1=0xFFFFFFF9, rs2=3 → md_req_op=MUL, out_sel=HI, s1=s2=1. Response 0xFFFFFFFF one cycle before wb_valid → wb_data=0xFFFFFFFF, wb_rd=in_rd.
- DIVU, rs1=100, rs2=7, md_req_ready held 0 for 3 cycles → md_req_valid held with stable operands. Response 14 → wb_data=14; wb_ready low 4 cycles → wb_valid and data held.
- REM accepted, kill asserted 2 cycles into WAIT → response pulse 0x2 discarded, wb_valid never rises, busy falls the cycle after the pulse; kill in ISSUE → md_req_valid never handshakes.
- TIMEOUT_CYCLES=8, no md_resp_valid → err=1 after 8 WAIT cycles, state IDLE; a later late pulse is ignored; err stays 1 until reset.
- Async reset asserted between edges while in DONE → wb_valid and busy go 0 without waiting for a clock edge.
- With VSCALE_MD_REUSE_EN: MUL 6*7 completes (42); repeat the same op with rd=9 → wb_valid at T+1, wb_data=42, wb_rd=9, zero md_req_valid cycles. Without the macro → full issue.

Source files
------------

// File: rtl/vscale_md_ctrl_pkg.sv
// Shared types and constants for the RV32M sequencer in front of vscale_mul_div.
// MD_OP_* / MD_OUT_* follow the encoding used by vscale_mul_div.
package vscale_md_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } md_state_e;

  localparam logic [2:0] MD_F3_MUL    = 3'b000;
  localparam logic [2:0] MD_F3_MULH   = 3'b001;
  localparam logic [2:0] MD_F3_MULHSU = 3'b010;
  localparam logic [2:0] MD_F3_MULHU  = 3'b011;
  localparam logic [2:0] MD_F3_DIV    = 3'b100;
  localparam logic [2:0] MD_F3_DIVU   = 3'b101;
  localparam logic [2:0] MD_F3_REM    = 3'b110;
  localparam logic [2:0] MD_F3_REMU   = 3'b111;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;
  localparam logic MD_OUT_LO = 1'b0;
  localparam logic MD_OUT_HI = 1'b1;

  localparam int unsigned MD_CNT_W = 8;

  typedef struct packed {
    logic op;
    logic out_sel;
    logic in_1_signed;
    logic in_2_signed;
  } md_dec_t;

endpackage

// File: rtl/vscale_md_ctrl_if.sv
// Pipeline, writeback and mul/div request/response signals of vscale_md_ctrl.
// The controller uses the slave modport; its environment uses master.
interface vscale_md_ctrl_if #(
  parameter int unsigned TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [TAG_W-1:0] in_rd;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic             kill;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_rd;
  logic [31:0]      wb_data;
  logic             busy;
  logic             err;
  logic             md_req_valid;
  logic             md_req_ready;
  logic             md_req_op;
  logic             md_req_out_sel;
  logic             md_req_in_1_signed;
  logic             md_req_in_2_signed;
  logic [31:0]      md_req_in_1;
  logic [31:0]      md_req_in_2;
  logic             md_resp_valid;
  logic [31:0]      md_resp_result;

  modport slave (
    input  in_valid, in_funct3, in_rd, in_rs1, in_rs2, kill, wb_ready,
    input  md_req_ready, md_resp_valid, md_resp_result,
    output in_ready, wb_valid, wb_rd, wb_data, busy, err,
    output md_req_valid, md_req_op, md_req_out_sel, md_req_in_1_signed,
    output md_req_in_2_signed, md_req_in_1, md_req_in_2
  );

  modport master (
    output in_valid, in_funct3, in_rd, in_rs1, in_rs2, kill, wb_ready,
    output md_req_ready, md_resp_valid, md_resp_result,
    input  in_ready, wb_valid, wb_rd, wb_data, busy, err,
    input  md_req_valid, md_req_op, md_req_out_sel, md_req_in_1_signed,
    input  md_req_in_2_signed, md_req_in_1, md_req_in_2
  );
endinterface

// File: rtl/vscale_md_decode.sv
// RV32M funct3 -> mul/div request fields (op, out_sel, operand signedness).
module vscale_md_decode
  import vscale_md_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  output md_dec_t    dec
);

  always_comb begin
    dec = '{MD_OP_MUL, MD_OUT_LO, 1'b0, 1'b0};
    case (funct3)
      MD_F3_MUL:    dec = '{MD_OP_MUL, MD_OUT_LO, 1'b0, 1'b0};
      MD_F3_MULH:   dec = '{MD_OP_MUL, MD_OUT_HI, 1'b1, 1'b1};
      MD_F3_MULHSU: dec = '{MD_OP_MUL, MD_OUT_HI, 1'b1, 1'b0};
      MD_F3_MULHU:  dec = '{MD_OP_MUL, MD_OUT_HI, 1'b0, 1'b0};
      MD_F3_DIV:    dec = '{MD_OP_DIV, MD_OUT_LO, 1'b1, 1'b1};
      MD_F3_DIVU:   dec = '{MD_OP_DIV, MD_OUT_LO, 1'b0, 1'b0};
      MD_F3_REM:    dec = '{MD_OP_DIV, MD_OUT_HI, 1'b1, 1'b1};
      MD_F3_REMU:   dec = '{MD_OP_DIV, MD_OUT_HI, 1'b0, 1'b0};
      default:      dec = '{MD_OP_MUL, MD_OUT_LO, 1'b0, 1'b0};
    endcase
  end

endmodule

// File: rtl/vscale_md_ctrl.sv
// Sequences one RV32M op into vscale_mul_div and holds the result for writeback.
// Define VSCALE_MD_REUSE_EN to bypass the unit when an op repeats the last result.
module vscale_md_ctrl
  import vscale_md_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 63,
  parameter int unsigned TAG_W          = 5
) (
  input logic              clk,
  input logic              reset,
  vscale_md_ctrl_if.slave  bus
);

  localparam logic [MD_CNT_W-1:0] CntLast = MD_CNT_W'(TIMEOUT_CYCLES - 1);

  md_state_e           state;
  md_dec_t             in_dec;
  md_dec_t             req_dec;
  logic [31:0]         req_in_1;
  logic [31:0]         req_in_2;
  logic [31:0]         wb_data_q;
  logic [TAG_W-1:0]    rd_q;
  logic [MD_CNT_W-1:0] cnt;
  logic                killed;
  logic                err_q;
  logic                in_ready;
  logic                accept;
  logic                kill_now;
  logic                cache_hit;
  logic [31:0]         cache_res;

  vscale_md_decode u_decode (
    .funct3 (bus.in_funct3),
    .dec    (in_dec)
  );

  assign in_ready = (state == StIdle) && !bus.kill && !reset;
  assign accept   = in_ready && bus.in_valid;
  // A kill landing on the response cycle still discards the result.
  assign kill_now = killed || bus.kill;

`ifdef VSCALE_MD_REUSE_EN
  logic        cache_vld;
  logic [2:0]  cache_f3;
  logic [2:0]  req_f3;
  logic [31:0] cache_rs1;
  logic [31:0] cache_rs2;
  logic        resp_ok;
  logic        timeout;

  assign resp_ok   = (state == StWait) && bus.md_resp_valid && !kill_now;
  assign timeout   = (state == StWait) && !bus.md_resp_valid && (cnt == CntLast);
  assign cache_hit = cache_vld && (cache_f3 == bus.in_funct3) &&
                     (cache_rs1 == bus.in_rs1) && (cache_rs2 == bus.in_rs2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_vld <= 1'b0;
      cache_f3  <= '0;
      req_f3    <= '0;
      cache_rs1 <= '0;
      cache_rs2 <= '0;
      cache_res <= '0;
    end else begin
      if (accept) req_f3 <= bus.in_funct3;
      if (resp_ok) begin
        cache_vld <= 1'b1;
        cache_f3  <= req_f3;
        cache_rs1 <= req_in_1;
        cache_rs2 <= req_in_2;
        cache_res <= bus.md_resp_result;
      end else if (timeout) begin
        cache_vld <= 1'b0;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      req_dec   <= '0;
      req_in_1  <= '0;
      req_in_2  <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      cnt       <= '0;
      killed    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            req_dec  <= in_dec;
            req_in_1 <= bus.in_rs1;
            req_in_2 <= bus.in_rs2;
            rd_q     <= bus.in_rd;
            if (cache_hit) begin
              wb_data_q <= cache_res;
              state     <= StDone;
            end else begin
              state <= StIssue;
            end
          end
        end
        StIssue: begin
          if (bus.kill) begin
            state <= StIdle;
          end else if (bus.md_req_ready) begin
            cnt   <= '0;
            state <= StWait;
          end
        end
        StWait: begin
          if (bus.md_resp_valid) begin
            killed <= 1'b0;
            if (kill_now) begin
              state <= StIdle;
            end else begin
              wb_data_q <= bus.md_resp_result;
              state     <= StDone;
            end
          end else if (cnt == CntLast) begin
            err_q  <= 1'b1;
            killed <= 1'b0;
            state  <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
            // The unit cannot abort, so a kill only marks the result for discard.
            if (bus.kill) killed <= 1'b1;
          end
        end
        StDone: begin
          if (bus.kill || bus.wb_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready           = in_ready;
  assign bus.busy               = (state != StIdle);
  assign bus.wb_valid           = (state == StDone);
  assign bus.wb_rd              = rd_q;
  assign bus.wb_data            = wb_data_q;
  assign bus.err                = err_q;
  assign bus.md_req_valid       = (state == StIssue);
  assign bus.md_req_op          = req_dec.op;
  assign bus.md_req_out_sel     = req_dec.out_sel;
  assign bus.md_req_in_1_signed = req_dec.in_1_signed;
  assign bus.md_req_in_2_signed = req_dec.in_2_signed;
  assign bus.md_req_in_1        = req_in_1;
  assign bus.md_req_in_2        = req_in_2;

endmodule

// File: tb/tb_vscale_md_ctrl.sv
// Self-checking bench for vscale_md_ctrl: decode table, corner-case sequences and
// randomized transactions checked against a transaction-level model.
module tb_vscale_md_ctrl;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  vscale_md_ctrl_if #(.TAG_W(5)) bus ();

  vscale_md_ctrl #(
    .TIMEOUT_CYCLES (8),
    .TAG_W          (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [2:0] f3;
    logic       op;
    logic       hi;
    logic       s1;
    logic       s2;
  } dec_vec_t;

  dec_vec_t dec_tab [8];

  // Model of the last completed (non-killed) real result.
  logic        mc_vld;
  logic [2:0]  mc_f3;
  logic [31:0] mc_rs1, mc_rs2, mc_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid       = 1'b0;
    bus.in_funct3      = '0;
    bus.in_rd          = '0;
    bus.in_rs1         = '0;
    bus.in_rs2         = '0;
    bus.kill           = 1'b0;
    bus.wb_ready       = 1'b0;
    bus.md_req_ready   = 1'b0;
    bus.md_resp_valid  = 1'b0;
    bus.md_resp_result = '0;
  endtask

  // kill_mode: 0 none, 1 kill on the handshake cycle of ISSUE, 2 kill on WAIT cycle kill_idx.
  // Entered and left just after a rising edge.
  task automatic run_txn(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd, input int ready_dly, input int resp_dly,
                         input int kill_mode, input int kill_idx, input int wb_dly,
                         input logic [31:0] res, input bit stray);
    bit          hit;
    bit          go;
    logic [31:0] exp_data;
    hit = 1'b0;
    go  = 1'b1;
`ifdef VSCALE_MD_REUSE_EN
    hit = mc_vld && (mc_f3 == f3) && (mc_rs1 == rs1) && (mc_rs2 == rs2);
`endif
    exp_data = hit ? mc_res : res;
    bus.in_valid = 1'b1; bus.in_funct3 = f3; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
    sample();
    check("in_ready_idle", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0; bus.in_funct3 = ~f3; bus.in_rs1 = ~rs1; bus.in_rs2 = ~rs2;
    bus.in_rd = ~rd;
    if (!hit) begin
      for (int i = 0; i <= ready_dly; i++) begin
        bus.md_req_ready   = (i == ready_dly);
        bus.kill           = (kill_mode == 1) && (i == ready_dly);
        bus.md_resp_valid  = stray && (i < ready_dly);
        bus.md_resp_result = $urandom;
        sample();
        check("issue_req_valid", bus.md_req_valid, 1'b1);
        check("issue_op", bus.md_req_op, dec_tab[f3].op);
        check("issue_out_sel", bus.md_req_out_sel, dec_tab[f3].hi);
        check("issue_s1", bus.md_req_in_1_signed, dec_tab[f3].s1);
        check("issue_s2", bus.md_req_in_2_signed, dec_tab[f3].s2);
        check("issue_in_1", bus.md_req_in_1, rs1);
        check("issue_in_2", bus.md_req_in_2, rs2);
        check("issue_in_ready", bus.in_ready, 1'b0);
        tick();
      end
      bus.md_req_ready = 1'b0; bus.kill = 1'b0; bus.md_resp_valid = 1'b0;
      if (kill_mode == 1) begin
        sample();
        check("kill_issue_req_valid", bus.md_req_valid, 1'b0);
        check("kill_issue_busy", bus.busy, 1'b0);
        check("kill_issue_wb_valid", bus.wb_valid, 1'b0);
        tick();
        go = 1'b0;
      end
    end
    if (!hit && go) begin
      for (int i = 0; i <= resp_dly; i++) begin
        bus.md_resp_valid  = (i == resp_dly);
        bus.md_resp_result = (i == resp_dly) ? res : $urandom;
        bus.kill           = (kill_mode == 2) && (i == kill_idx);
        sample();
        check("wait_req_valid", bus.md_req_valid, 1'b0);
        check("wait_busy", bus.busy, 1'b1);
        check("wait_wb_valid", bus.wb_valid, 1'b0);
        tick();
      end
      bus.md_resp_valid = 1'b0; bus.kill = 1'b0;
      if (kill_mode == 2) begin
        sample();
        check("kill_wait_wb_valid", bus.wb_valid, 1'b0);
        check("kill_wait_busy", bus.busy, 1'b0);
        tick();
        go = 1'b0;
      end
    end
    if (go) begin
      for (int i = 0; i <= wb_dly; i++) begin
        bus.wb_ready       = (i == wb_dly);
        bus.md_resp_valid  = stray && (i < wb_dly);
        bus.md_resp_result = $urandom;
        sample();
        check("done_wb_valid", bus.wb_valid, 1'b1);
        check("done_wb_data", bus.wb_data, exp_data);
        check("done_wb_rd", bus.wb_rd, rd);
        check("done_req_valid", bus.md_req_valid, 1'b0);
        tick();
      end
      bus.wb_ready = 1'b0; bus.md_resp_valid = 1'b0;
      sample();
      check("after_wb_valid", bus.wb_valid, 1'b0);
      check("after_wb_busy", bus.busy, 1'b0);
      tick();
      if (!hit) begin
        mc_vld = 1'b1; mc_f3 = f3; mc_rs1 = rs1; mc_rs2 = rs2; mc_res = res;
      end
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          rdly, kmode;

    dec_tab[0] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    dec_tab[1] = '{3'b001, 1'b0, 1'b1, 1'b1, 1'b1};
    dec_tab[2] = '{3'b010, 1'b0, 1'b1, 1'b1, 1'b0};
    dec_tab[3] = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b0};
    dec_tab[4] = '{3'b100, 1'b1, 1'b0, 1'b1, 1'b1};
    dec_tab[5] = '{3'b101, 1'b1, 1'b0, 1'b0, 1'b0};
    dec_tab[6] = '{3'b110, 1'b1, 1'b1, 1'b1, 1'b1};
    dec_tab[7] = '{3'b111, 1'b1, 1'b1, 1'b0, 1'b0};
    mc_vld = 1'b0; mc_f3 = '0; mc_rs1 = '0; mc_rs2 = '0; mc_res = '0;

    idle_inputs();
    reset = 1'b1;
    #2;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_req_valid", bus.md_req_valid, 1'b0);
    check("rst_wb_data", bus.wb_data, 32'h0);
    check("rst_wb_rd", bus.wb_rd, 5'h0);
    check("rst_req_in_1", bus.md_req_in_1, 32'h0);
    @(posedge clk);
    tick();
    reset = 1'b0;
    sample();
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    tick();

    // Decode table: one clean transaction per funct3.
    for (int k = 0; k < 8; k++) begin
      run_txn(dec_tab[k].f3, $urandom, $urandom, 5'(k + 1), 0, 1, 0, 0, 0, $urandom, 1'b0);
    end

    // kill held in IDLE blocks acceptance.
    bus.in_valid = 1'b1; bus.kill = 1'b1;
    sample();
    check("kill_idle_in_ready", bus.in_ready, 1'b0);
    tick();
    bus.in_valid = 1'b0; bus.kill = 1'b0;
    sample();
    check("kill_idle_busy", bus.busy, 1'b0);
    tick();

    // MULH, response on the first WAIT cycle.
    run_txn(3'b001, 32'hFFFF_FFF9, 32'd3, 5'd11, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1'b0);
    // DIVU with request backpressure, writeback backpressure and stray pulses.
    run_txn(3'b101, 32'd100, 32'd7, 5'd12, 3, 2, 0, 0, 4, 32'd14, 1'b1);
    // REM killed two cycles into WAIT; then kill in ISSUE.
    run_txn(3'b110, 32'd20, 32'd6, 5'd13, 0, 3, 2, 2, 0, 32'h2, 1'b0);
    run_txn(3'b110, 32'd21, 32'd6, 5'd14, 2, 0, 1, 0, 0, 32'h3, 1'b0);

    // Watchdog: eight silent WAIT cycles raise err.
    bus.in_valid = 1'b1; bus.in_funct3 = 3'b100; bus.in_rs1 = 32'd9; bus.in_rs2 = 32'd0;
    bus.in_rd = 5'd7;
    sample();
    tick();
    bus.in_valid = 1'b0; bus.md_req_ready = 1'b1;
    sample();
    check("to_req_valid", bus.md_req_valid, 1'b1);
    tick();
    bus.md_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      check("to_err_low", bus.err, 1'b0);
      check("to_busy", bus.busy, 1'b1);
      tick();
    end
    sample();
    check("to_err_set", bus.err, 1'b1);
    check("to_idle", bus.busy, 1'b0);
    tick();
    mc_vld = 1'b0;
    bus.md_resp_valid = 1'b1; bus.md_resp_result = 32'hDEAD;
    sample();
    tick();
    bus.md_resp_valid = 1'b0;
    sample();
    check("late_pulse_wb_valid", bus.wb_valid, 1'b0);
    check("late_pulse_busy", bus.busy, 1'b0);
    tick();
    run_txn(3'b000, 32'd5, 32'd5, 5'd2, 1, 1, 0, 0, 1, 32'd25, 1'b0);
    sample();
    check("err_sticky", bus.err, 1'b1);
    tick();

    // Asynchronous reset between edges while in DONE.
    bus.in_valid = 1'b1; bus.in_funct3 = 3'b000; bus.in_rs1 = 32'd3; bus.in_rs2 = 32'd5;
    bus.in_rd = 5'd4;
    sample();
    tick();
    bus.in_valid = 1'b0; bus.md_req_ready = 1'b1;
    sample();
    tick();
    bus.md_req_ready = 1'b0; bus.md_resp_valid = 1'b1; bus.md_resp_result = 32'd15;
    sample();
    tick();
    bus.md_resp_valid = 1'b0;
    sample();
    check("arst_pre_wb_valid", bus.wb_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_wb_valid", bus.wb_valid, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    #1 reset = 1'b0;
    mc_vld = 1'b0;
    tick();
    sample();
    check("arst_err_clear", bus.err, 1'b0);
    check("arst_in_ready", bus.in_ready, 1'b1);
    tick();

    // Repeat of an identical op: bypassed with the reuse cache, fully issued without it.
    run_txn(3'b000, 32'd6, 32'd7, 5'd3, 0, 1, 0, 0, 0, 32'd42, 1'b0);
    run_txn(3'b000, 32'd6, 32'd7, 5'd9, 0, 1, 0, 0, 0, 32'd42, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (mc_vld && ($urandom_range(0, 3) == 0)) begin
        f3 = mc_f3; a = mc_rs1; b = mc_rs2;
      end
      rdly  = $urandom_range(0, 6);
      kmode = $urandom_range(0, 5);
      kmode = (kmode == 0) ? 1 : (kmode == 1) ? 2 : 0;
      run_txn(f3, a, b, 5'($urandom), $urandom_range(0, 3), rdly, kmode,
              $urandom_range(0, rdly), $urandom_range(0, 3), $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
